bus_rr_mux: RTL and testbench
=============================

# bus_rr_mux

Parametrised N-channel arbitrated data multiplexer for the simpleBUS datapath. It is the successor to the fixed 3-input, 32-bit combinational select. Channel selection is no longer driven by an external select code: it comes from an internal round-robin arbiter with a bounded burst hold. The selected word is registered into a one-entry output stage with a valid/ready handshake toward the bus consumer.

## Interface
- WIDTH, 32, data width per channel.
- NUM_CH, 3, number of requesting channels (legal range >= 2).
- MAX_HOLD, 4, maximum beats accepted per grant before the grant is released (legal range >= 1).
- SEL_W (localparam) = max(1, clog2(NUM_CH)).

- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_CH  per-channel request/data-valid; bit i belongs to channel i.
- din  in  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- ack  out  NUM_CH  combinational one-hot; the channel's word is captured at this edge.
- grant  out  NUM_CH  registered one-hot grant; all zero when idle.
- sel  out  SEL_W  registered index of the granted channel; 0 when idle.
- dout  out  WIDTH  registered output word.
- valid  out  1  dout holds an untaken word.
- ready  in  1  consumer accepts dout when valid && ready.

## Operation
- State machine with two states, IDLE and GRANT, plus these registers: round-robin pointer ptr (SEL_W bits), beat counter cnt (width clog2(MAX_HOLD)+1), and the output register.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise, grant the first channel with req=1, searching ptr+1, ptr+2, … modulo NUM_CH.
  - At the same edge: grant <= onehot(i), sel <= i, ptr <= i, cnt <= 0, state <= GRANT.
- Output-stage free condition: out_free = !valid || ready.
- Acknowledge: ack[i] = (state==GRANT) && grant[i] && req[i] && out_free. At most one ack bit is ever set.
- Output register update:
  - When ack is set: dout <= din[sel], valid <= 1, cnt <= cnt+1.
  - Else when ready: valid <= 0, dout holds its value.
  - A simultaneous take-and-load (valid && ready && ack) replaces the word with no bubble.
- GRANT releases to IDLE at an edge when either condition holds:
  - req[sel]==0; or
  - ack is set and cnt==MAX_HOLD-1.
- On release: grant <= 0, sel <= 0. The output register is unaffected, so a pending word stays valid until taken.
- Round robin: the channel just served gets lowest priority at the next arbitration. With all channels requesting continuously, service order is 0,1,…,NUM_CH-1,0,…
- Requests from non-granted channels are ignored while in GRANT. Masters must hold req and din stable until acked.
- Reset (asynchronous, any time including mid-burst):
  - state=IDLE, grant=0, sel=0, valid=0, dout=0, cnt=0, ptr=NUM_CH-1, so channel 0 wins first.
  - A word in flight is discarded.

## Timing
- Arbitration latency: req rising in IDLE in cycle 0 → grant/sel set after edge 0 → ack possible in cycle 1 → valid=1, dout=word in cycle 2.
- Throughput within a grant: one beat per cycle while ready=1.
- Backpressure: ready=0 with valid=1 stalls ack. cnt does not advance and the grant is held.
- Release overhead: one IDLE cycle (grant=0) between consecutive grants. Sustained multi-channel bus utilisation is MAX_HOLD/(MAX_HOLD+1).
- Deassertion of req[sel] takes effect at the next edge. No ack is produced in a cycle where req[sel]=0.
- ack is combinational from req, ready, and registered state. There is no combinational path from din to any output.

## Test plan
- Reset/first grant: hold reset_n=0, then release. Check all outputs are 0. Drive req=3'b111 with din0=0xA0, din1=0xB1, din2=0xC2 and ready=1. Required: grant=3'b001 one cycle later, valid with dout=0xA0 two cycles after req.
- Hold limit: MAX_HOLD=4, req=3'b111 constant, ready=1. Required: channel 0 acked exactly 4 consecutive cycles, then 1 IDLE cycle, then channel 1 for 4 beats, then channel 2, then channel 0.
- Backpressure: single channel 1 streaming 0x11, 0x22, 0x33, ready=0 for 3 cycles after the first beat. Required: valid=1 with dout=0x11 held, ack=0 and cnt frozen during the stall. Then 0x22 and 0x33 follow on consecutive cycles once ready=1.
- Early release: channel 2 requests, gets acked for 2 beats, then drops req. Required: grant returns to 0 at the next edge, and valid stays 1 with the last word until ready=1.
- Fairness after idle: serve channel 1, go idle, then assert req=3'b011. Required: channel 0 is granted first, because ptr=1 gives channel 1 lowest priority.
- Reset mid-burst: pull reset_n low asynchronously while valid=1 and grant=3'b010. Required: valid, grant, sel, and dout go to 0 immediately without waiting for clk, and arbitration restarts from channel 0.

Source files
------------

// File: rtl/bus_rr_mux.sv
// bus_rr_mux: N-channel round-robin arbitrated data multiplexer with bounded
// burst hold and a one-entry registered output stage (valid/ready).
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [NUM_CH]        per-channel request / data-valid
//   din      in   [NUM_CH*WIDTH]  flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   ack      out  [NUM_CH]        combinational one-hot; channel word captured this edge
//   grant    out  [NUM_CH]        registered one-hot grant, zero when idle
//   sel      out  [SEL_W]         registered granted channel index, zero when idle
//   dout     out  [WIDTH]         registered output word
//   valid    out                  dout holds an untaken word
//   ready    in                   consumer takes dout when valid && ready
module bus_rr_mux #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned MAX_HOLD = 4,
    localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*WIDTH-1:0] din,
    output logic [NUM_CH-1:0]       ack,
    output logic [NUM_CH-1:0]       grant,
    output logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        dout,
    output logic                    valid,
    input  logic                    ready
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q,   sel_d;
    logic [SEL_W-1:0]    ptr_q,   ptr_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0]    dout_q,  dout_d;
    logic                valid_q, valid_d;

    logic                out_free;
    logic                ack_any;
    logic                found;
    logic [SEL_W-1:0]    win;
    logic [SEL_W-1:0]    cand;
    logic [WIDTH-1:0]    sel_data;

    // Output stage can accept a new word when empty or being drained this cycle.
    assign out_free = !valid_q || ready;

    // grant_q is one-hot, so at most one ack bit can be set.
    assign ack     = (state_q == GRANT && out_free) ? (grant_q & req) : '0;
    assign ack_any = |ack;

    assign sel_data = din[int'(sel_q)*WIDTH +: WIDTH];

    // Round-robin search starting just after the last served channel.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            cand = SEL_W'((int'(ptr_q) + k) % int'(NUM_CH));
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state, grant and output-stage logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;

        if (ack_any) begin
            dout_d  = sel_data;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = win;
                    ptr_d   = win;
                    cnt_d   = '0;
                    for (int i = 0; i < int'(NUM_CH); i++) begin
                        grant_d[i] = (i == int'(win));
                    end
                end
            end
            GRANT: begin
                // Release on dropped request or on the last beat of the hold window.
                if (!req[sel_q] || (ack_any && cnt_q == CNT_W'(MAX_HOLD - 1))) begin
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase
    end

    // State registers; reset points ptr at the last channel so channel 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(NUM_CH - 1);
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign dout  = dout_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_bus_rr_mux.sv
// tb_bus_rr_mux: directed bench for bus_rr_mux (WIDTH=32, NUM_CH=3, MAX_HOLD=4).
module tb_bus_rr_mux;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_CH = 3;

    logic                    clk;
    logic                    reset_n;
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH*WIDTH-1:0] din;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       grant;
    logic [1:0]              sel;
    logic [WIDTH-1:0]        dout;
    logic                    valid;
    logic                    ready;

    int n_assert;
    int n_fail;

    bus_rr_mux #(
        .WIDTH   (32),
        .NUM_CH  (3),
        .MAX_HOLD(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .din    (din),
        .ack    (ack),
        .grant  (grant),
        .sel    (sel),
        .dout   (dout),
        .valid  (valid),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then let registered outputs settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_din(input int c, input logic [31:0] v);
        din[c*WIDTH +: WIDTH] = v;
    endtask

    function automatic logic [2:0] oh(input int c);
        logic [2:0] one;
        one = 3'b001;
        return one << c;
    endfunction

    logic [31:0] dat [3];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        req      = '0;
        din      = '0;
        ready    = 1'b0;
        dat[0]   = 32'hA0;
        dat[1]   = 32'hB1;
        dat[2]   = 32'hC2;

        // Reset state
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel",   32'(sel),   32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_dout",  dout,       32'h0);
        chk("rst_ack",   32'(ack),   32'h0);
        reset_n = 1'b1;
        step();

        // First grant: cycle 0 req rises
        req   = 3'b111;
        set_din(0, dat[0]);
        set_din(1, dat[1]);
        set_din(2, dat[2]);
        ready = 1'b1;
        #1;
        chk("first_c0_grant", 32'(grant), 32'h0);
        chk("first_c0_ack",   32'(ack),   32'h0);
        step();
        chk("first_c1_sel", 32'(sel), 32'h0);

        // Hold limit: 4 beats per channel, one idle cycle, rotation 0,1,2,0
        for (int c = 0; c < 3; c++) begin
            for (int b = 0; b < 4; b++) begin
                chk("hold_ack",   32'(ack),   32'(oh(c)));
                chk("hold_grant", 32'(grant), 32'(oh(c)));
                if (b > 0) begin
                    chk("hold_valid", 32'(valid), 32'h1);
                    chk("hold_dout",  dout,       dat[c]);
                end
                step();
            end
            chk("hold_idle_grant", 32'(grant), 32'h0);
            chk("hold_idle_ack",   32'(ack),   32'h0);
            chk("hold_idle_valid", 32'(valid), 32'h1);
            chk("hold_idle_dout",  dout,       dat[c]);
            step();
        end
        chk("hold_wrap_grant", 32'(grant), 32'h1);
        chk("hold_wrap_ack",   32'(ack),   32'h1);
        step();
        req = '0;
        #1;
        step();
        step();
        chk("hold_end_grant", 32'(grant), 32'h0);
        chk("hold_end_valid", 32'(valid), 32'h0);

        // Backpressure on channel 1 (ptr=0, so channel 1 wins)
        req = 3'b010;
        set_din(1, 32'h11);
        #1;
        step();
        chk("bp_grant", 32'(grant), 32'h2);
        chk("bp_ack1",  32'(ack),   32'h2);
        step();
        set_din(1, 32'h22);
        ready = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("bp_stall_valid", 32'(valid), 32'h1);
            chk("bp_stall_dout",  dout,       32'h11);
            chk("bp_stall_ack",   32'(ack),   32'h0);
            chk("bp_stall_grant", 32'(grant), 32'h2);
            chk("bp_stall_cnt",   32'(dut.cnt_q), 32'h1);
            step();
        end
        ready = 1'b1;
        #1;
        chk("bp_resume_ack", 32'(ack), 32'h2);
        step();
        set_din(1, 32'h33);
        #1;
        chk("bp_dout22", dout,       32'h22);
        chk("bp_ack33",  32'(ack),   32'h2);
        step();
        req = '0;
        #1;
        chk("bp_dout33", dout,       32'h33);
        chk("bp_valid",  32'(valid), 32'h1);
        chk("bp_noack",  32'(ack),   32'h0);
        step();
        chk("bp_rel_grant", 32'(grant), 32'h0);
        chk("bp_rel_valid", 32'(valid), 32'h0);
        step();

        // Fairness after idle: ptr=1, so channel 0 beats channel 1
        req = 3'b011;
        set_din(0, 32'h5A);
        set_din(1, 32'h6B);
        #1;
        step();
        chk("fair_grant", 32'(grant), 32'h1);
        chk("fair_sel",   32'(sel),   32'h0);
        chk("fair_ack",   32'(ack),   32'h1);
        req = '0;
        #1;
        step();
        step();
        chk("fair_end_grant", 32'(grant), 32'h0);

        // Early release on channel 2 (ptr=0)
        req = 3'b100;
        set_din(2, 32'h21);
        #1;
        step();
        chk("early_grant", 32'(grant), 32'h4);
        chk("early_ack1",  32'(ack),   32'h4);
        step();
        set_din(2, 32'h22);
        #1;
        chk("early_ack2", 32'(ack), 32'h4);
        chk("early_dout1", dout,    32'h21);
        step();
        req   = '0;
        ready = 1'b0;
        #1;
        chk("early_drop_ack",  32'(ack),   32'h0);
        chk("early_drop_dout", dout,       32'h22);
        step();
        chk("early_rel_grant", 32'(grant), 32'h0);
        chk("early_rel_sel",   32'(sel),   32'h0);
        chk("early_rel_valid", 32'(valid), 32'h1);
        chk("early_rel_dout",  dout,       32'h22);
        step();
        chk("early_hold_valid", 32'(valid), 32'h1);
        ready = 1'b1;
        #1;
        step();
        chk("early_taken_valid", 32'(valid), 32'h0);

        // Reset mid-burst on channel 1 (ptr=2 wraps to 0 first, so only ch1 requests)
        req = 3'b010;
        set_din(1, 32'h77);
        #1;
        step();
        chk("mid_grant", 32'(grant), 32'h2);
        step();
        chk("mid_valid_pre", 32'(valid), 32'h1);
        chk("mid_dout_pre",  dout,       32'h77);
        chk("mid_grant_pre", 32'(grant), 32'h2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_sel",   32'(sel),   32'h0);
        chk("mid_rst_dout",  dout,       32'h0);
        chk("mid_rst_ack",   32'(ack),   32'h0);
        step();
        reset_n = 1'b1;
        req     = 3'b111;
        #1;
        step();
        chk("mid_restart_grant", 32'(grant), 32'h1);
        chk("mid_restart_ack",   32'(ack),   32'h1);
        req = '0;
        #1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
